// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
//   Shared types and constants for the I-cache / D-cache memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - REQ_I/REQ_D : requester IDs, also the bit positions in the request vector
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    I_ACCESS = 2'd1,
    D_ACCESS = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Pack the two request lines so that bit index equals requester ID.
  function automatic logic [1:0] req_vec(input logic i_req, input logic d_req);
    return {d_req, i_req};
  endfunction

endpackage

// File: rtl/arb_rr_pick2.sv
// arb_rr_pick2
//   Two-way round-robin pick. On a tie the requester that was not granted
//   last wins; a lone request wins outright.
//   Ports:
//     req   in  2  request vector, bit index = requester ID
//     last  in  1  ID granted most recently
//     grant out 1  ID to grant (only meaningful when req != 0)
module arb_rr_pick2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Priority selection between the two requesters.
  always_comb begin
    grant = REQ_D;
    case (req)
      2'b11:   grant = ~last;
      2'b10:   grant = REQ_D;
      2'b01:   grant = REQ_I;
      default: grant = ~last;  // no request: result is ignored by the caller
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Arbitrates an instruction-cache block-read port and a data-cache
//   fill/write-back port onto a single main-memory port. One access at a
//   time: IDLE -> ACCESS (command held until mem_busywait low) -> RESP (ack
//   pulse) -> IDLE. Ties are resolved round-robin; after reset D wins first.
//   Ports:
//     clk, reset                   clock, async active-high reset
//     i_req/i_addr/i_rdata/i_ack   instruction-cache requester
//     d_req/d_write/d_addr/d_wdata/d_rdata/d_ack  data-cache requester
//     mem_read/mem_write/mem_addr/mem_writedata/mem_readdata/mem_busywait
//                                  main-memory port
//     arb_timeout                  sticky watchdog flag (ARB_TIMEOUT_EN only)
//   Configuration macro: ARB_TIMEOUT_EN adds an access watchdog that aborts
//   an access after TIMEOUT_CYCLES cycles and raises arb_timeout.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int BLOCK_SIZE     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [BLOCK_SIZE*8-1:0] i_rdata,
  output logic                    i_ack,
  input  logic                    d_req,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [BLOCK_SIZE*8-1:0] d_wdata,
  output logic [BLOCK_SIZE*8-1:0] d_rdata,
  output logic                    d_ack,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BLOCK_SIZE*8-1:0] mem_writedata,
  input  logic [BLOCK_SIZE*8-1:0] mem_readdata,
  input  logic                    mem_busywait
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                    arb_timeout
`endif
);

  localparam int DW = BLOCK_SIZE * 8;

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DW-1:0]         i_rdata_q, i_rdata_d;
  logic [DW-1:0]         d_rdata_q, d_rdata_d;

  logic                  grant_s;
  logic                  in_access_s;
  logic                  abort_s;
  logic [DW-1:0]         rsp_data_s;

  arb_rr_pick2 u_pick (
    .req   (req_vec(i_req, d_req)),
    .last  (last_q),
    .grant (grant_s)
  );

  assign in_access_s = (state_q == I_ACCESS) || (state_q == D_ACCESS);
  // A watchdog abort returns an all-zero block instead of the bus value.
  assign rsp_data_s  = abort_s ? {DW{1'b0}} : mem_readdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // cnt_q counts completed busy cycles of the current access, so the abort
  // edge is the one ending the TIMEOUT_CYCLES-th access cycle.
  assign abort_s = in_access_s && mem_busywait &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and sticky timeout flag next-state.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (in_access_s) begin
      if (abort_s) begin
        cnt_d     = {CNT_W{1'b0}};
        timeout_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign abort_s = 1'b0;

  // The watchdog limit has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 32'sd0);
`endif

  // FSM next-state, operand capture, command and response generation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_d = grant_s;
          if (grant_s == REQ_D) begin
            addr_d      = d_addr;
            write_d     = d_write;
            wdata_d     = d_wdata;
            mem_read_d  = ~d_write;
            mem_write_d = d_write;
            state_d     = D_ACCESS;
          end else begin
            addr_d      = i_addr;
            write_d     = 1'b0;
            wdata_d     = {DW{1'b0}};
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            state_d     = I_ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end

      I_ACCESS, D_ACCESS: begin
        if (!mem_busywait || abort_s) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == D_ACCESS) begin
            d_ack_d = 1'b1;
            // A write-back returns nothing; keep the previous fill block.
            if (write_q) begin
              d_rdata_d = d_rdata_q;
            end else begin
              d_rdata_d = rsp_data_s;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = rsp_data_s;
          end
        end else begin
          state_d = state_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= REQ_I;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      write_q     <= 1'b0;
      wdata_q     <= {DW{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = addr_q;
  assign mem_writedata = wdata_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Scoreboard bench: stimulus pushes the expected access (id, command,
//   address, data, returned block, command-cycle count) in expected grant
//   order; a monitor compares every command cycle and every ack against the
//   queue head. Memory latency is set per access through busy_n.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait = 1'b0;
`ifdef ARB_TIMEOUT_EN
  logic          arb_timeout;
`endif

  cache_mem_arbiter #(
    .BLOCK_SIZE     (8),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_rdata       (i_rdata),
    .i_ack         (i_ack),
    .d_req         (d_req),
    .d_write       (d_write),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_ack         (d_ack),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef ARB_TIMEOUT_EN
    ,
    .arb_timeout   (arb_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: 0x100 holds a fixed pattern, every other block is tagged.
  assign mem_readdata = (mem_addr == 32'h0000_0100) ? 64'hAABB_CCDD_EEFF_0011
                                                    : {32'hC0DE_0000, mem_addr};

  typedef struct {
    logic          id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_chk    = 0;
  int   busy_n   = 0;
  int   ack_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic id, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                          input int cycles);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"},      64'(mem_read), 64'd0);
    chk({tag, "_mem_write"},     64'(mem_write), 64'd0);
    chk({tag, "_mem_addr"},      64'(mem_addr), 64'd0);
    chk({tag, "_mem_writedata"}, mem_writedata, 64'd0);
    chk({tag, "_i_ack"},         64'(i_ack), 64'd0);
    chk({tag, "_d_ack"},         64'(d_ack), 64'd0);
    chk({tag, "_i_rdata"},       i_rdata, 64'd0);
    chk({tag, "_d_rdata"},       d_rdata, 64'd0);
  endtask

  // Requester I: hold req until ack, drop it on the edge ending the ack cycle.
  task automatic run_i(input logic [AW-1:0] a, input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    i_addr = a;
    i_req  = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (i_ack) got = 1'b1;
    end
    chk("i_ack_seen", 64'(got), 64'd1);
    if (exp_lat != 0) chk("i_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic run_d(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    d_write = wr;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (d_ack) got = 1'b1;
    end
    chk("d_ack_seen", 64'(got), 64'd1);
    if (exp_lat != 0) chk("d_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    d_req   = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Memory model: busywait high for the first busy_n cycles of each command.
  initial begin
    int acc_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) begin
        mem_busywait = (acc_cnt < busy_n);
        acc_cnt++;
      end else begin
        acc_cnt      = 0;
        mem_busywait = 1'b0;
      end
    end
  end

  // Monitor: compare command cycles and acks against the scoreboard head.
  initial begin
    logic prev_cmd;
    logic prev_ack;
    int   cyc;
    exp_t e;
    prev_cmd = 1'b0;
    prev_ack = 1'b0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_cmd = 1'b0;
        prev_ack = 1'b0;
        cyc      = 0;
      end else begin
        if (mem_read || mem_write) begin
          chk("cmd_onehot", 64'(mem_read & mem_write), 64'd0);
          chk("cmd_with_expectation", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("cmd_write_flag", 64'(mem_write), 64'(exp_q[0].wr));
            chk("cmd_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            chk("cmd_writedata", mem_writedata, exp_q[0].wdata);
          end
          cyc++;
        end
        if (i_ack || d_ack) begin
          ack_seen++;
          chk("ack_onehot", 64'(i_ack & d_ack), 64'd0);
          chk("ack_after_cmd", 64'({prev_cmd, mem_read | mem_write}), 64'd2);
          chk("ack_one_cycle", 64'(prev_ack), 64'd0);
          chk("ack_with_expectation", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_id", 64'(d_ack), 64'(e.id));
            chk("ack_rdata", (e.id == REQ_D) ? d_rdata : i_rdata, e.rdata);
            chk("ack_cmd_cycles", 64'(cyc), 64'(e.cycles));
          end
          cyc = 0;
        end
        prev_cmd = mem_read | mem_write;
        prev_ack = i_ack | d_ack;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ia_tbl [2];
    logic [AW-1:0] da_tbl [2];
    int            acks_before;
    ia_tbl[0] = 32'h0000_0A00; ia_tbl[1] = 32'h0000_0B00;
    da_tbl[0] = 32'h0000_0A80; da_tbl[1] = 32'h0000_0B80;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
`ifdef ARB_TIMEOUT_EN
    chk("reset_arb_timeout", 64'(arb_timeout), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Tie right after reset: D first, then I.
    busy_n = 1;
    push_exp(REQ_D, 1'b0, 32'h500, 64'd0, 64'hC0DE_0000_0000_0500, 2);
    push_exp(REQ_I, 1'b0, 32'h400, 64'd0, 64'hC0DE_0000_0000_0400, 2);
    fork
      run_d(1'b0, 32'h500, 64'd0, 0);
      run_i(32'h400, 0);
    join

    // Single I read, 3 busy cycles: 4 command cycles, ack 6 cycles after req.
    busy_n = 3;
    push_exp(REQ_I, 1'b0, 32'h100, 64'd0, 64'hAABB_CCDD_EEFF_0011, 4);
    run_i(32'h100, 6);

    // D fill with no wait state: minimum latency 3.
    busy_n = 0;
    push_exp(REQ_D, 1'b0, 32'h300, 64'd0, 64'hC0DE_0000_0000_0300, 1);
    run_d(1'b0, 32'h300, 64'd0, 3);

    // D write-back: d_rdata must keep the previous fill block.
    busy_n = 2;
    push_exp(REQ_D, 1'b1, 32'h200, 64'h1122_3344_5566_7788, 64'hC0DE_0000_0000_0300, 3);
    run_d(1'b1, 32'h200, 64'h1122_3344_5566_7788, 5);
    chk("i_rdata_held", i_rdata, 64'hAABB_CCDD_EEFF_0011);

    // D was granted last, so this tie goes to I.
    busy_n = 0;
    push_exp(REQ_I, 1'b0, 32'h800, 64'd0, 64'hC0DE_0000_0000_0800, 1);
    push_exp(REQ_D, 1'b0, 32'h900, 64'd0, 64'hC0DE_0000_0000_0900, 1);
    fork
      run_i(32'h800, 0);
      run_d(1'b0, 32'h900, 64'd0, 0);
    join

    // Back-to-back tie rounds keep alternating.
    for (int r = 0; r < 2; r++) begin
      busy_n = 1;
      push_exp(REQ_I, 1'b0, ia_tbl[r], 64'd0, {32'hC0DE_0000, ia_tbl[r]}, 2);
      push_exp(REQ_D, 1'b0, da_tbl[r], 64'd0, {32'hC0DE_0000, da_tbl[r]}, 2);
      fork
        run_i(ia_tbl[r], 0);
        run_d(1'b0, da_tbl[r], 64'd0, 0);
      join
    end

    // Request dropped one cycle into the access still completes and acks.
    busy_n = 3;
    push_exp(REQ_I, 1'b0, 32'h700, 64'd0, 64'hC0DE_0000_0000_0700, 4);
    i_addr = 32'h700;
    i_req  = 1'b1;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    wait_drain(30);

    // Reset during a D write access: everything clears at once, no ack later.
    busy_n = 50;
    push_exp(REQ_D, 1'b1, 32'h600, 64'h5555_AAAA_5555_AAAA, 64'd0, 0);
    d_write = 1'b1;
    d_addr  = 32'h600;
    d_wdata = 64'h5555_AAAA_5555_AAAA;
    d_req   = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    d_req   = 1'b0;
    d_write = 1'b0;
    acks_before = ack_seen;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    busy_n = 0;
    repeat (10) @(negedge clk);
    chk("no_ack_after_reset", 64'(ack_seen - acks_before), 64'd0);
    chk("no_cmd_after_reset", 64'({mem_read, mem_write}), 64'd0);

    // Last-grant returned to I by reset, so D wins this tie.
    @(posedge clk);
    #1;
    push_exp(REQ_D, 1'b0, 32'hD00, 64'd0, 64'hC0DE_0000_0000_0D00, 1);
    push_exp(REQ_I, 1'b0, 32'hC00, 64'd0, 64'hC0DE_0000_0000_0C00, 1);
    fork
      run_d(1'b0, 32'hD00, 64'd0, 0);
      run_i(32'hC00, 0);
    join

`ifdef ARB_TIMEOUT_EN
    // Memory stuck busy: abort after 8 access cycles, block returned as zero.
    chk("timeout_flag_before", 64'(arb_timeout), 64'd0);
    busy_n = 1000;
    push_exp(REQ_I, 1'b0, 32'hE00, 64'd0, 64'd0, 8);
    run_i(32'hE00, 10);
    chk("timeout_flag_set", 64'(arb_timeout), 64'd1);
    busy_n = 0;
    push_exp(REQ_I, 1'b0, 32'hF00, 64'd0, 64'hC0DE_0000_0000_0F00, 1);
    run_i(32'hF00, 3);
    chk("timeout_flag_sticky", 64'(arb_timeout), 64'd1);
`endif

    wait_drain(50);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
